dpram_fifo_ctrl: RTL and testbench

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

---
 rtl/dpram_pkg.sv | 14 +
 rtl/dpram_ptr.sv | 22 ++
 rtl/dpram_fifo_ctrl.sv | 92 +++++++++
 tb/tb_dpram_fifo_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared defaults for the dual-port-RAM FIFO controller and its pointer sub-block.
package dpram_pkg;

  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 8;
  localparam int DEPTH_DEF = 2 ** AW_DEF;
  localparam int CW_DEF    = AW_DEF + 1;

  // Occupancy needs one bit more than the address so that "full" (2**AW) fits.
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/dpram_ptr.sv
// AW-bit wrapping pointer with increment enable and synchronous clear.
module dpram_ptr #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external simple dual-port RAM (port A write, port B
// registered read); tracks occupancy, status flags and sticky over/underflow.
module dpram_fifo_ctrl
  import dpram_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int AFULL_TH = 2 ** AW - 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          unf,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dina,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_doutb
);

  localparam int CW    = count_width(AW);
  localparam int DEPTH = 2 ** AW;

  logic          wr_acc;
  logic          rd_acc;
  logic [1:0]    ptr_inc;
  logic [AW-1:0] ptr_val [2];

  // rst_n gating keeps both RAM ports idle while reset is held, even mid-cycle.
  assign wr_acc = rst_n && !flush && wr_en && !full;
  assign rd_acc = rst_n && !flush && rd_en && !empty;

  assign ptr_inc = {rd_acc, wr_acc};

  // Index 0 is the write pointer, index 1 the read pointer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
    dpram_ptr #(.AW(AW)) u_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (ptr_inc[gi]),
      .ptr   (ptr_val[gi])
    );
  end

  assign ram_wea   = wr_acc;
  assign ram_addra = ptr_val[0];
  assign ram_dina  = wr_data;
  assign ram_enb   = rd_acc;
  assign ram_addrb = ptr_val[1];

  assign rd_data = ram_doutb;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign afull = (count >= CW'(AFULL_TH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (flush) begin
      count    <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) ovf <= 1'b1;
      if (rd_en && empty) unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench: controller paired with a behavioural dual-port RAM and a data-order queue.
module tb_dpram_fifo_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full, empty, afull;
  logic [AW:0]   count;
  logic          ovf, unf;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] exp_q [$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DW(DW), .AW(AW), .AFULL_TH(2**AW-4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .afull     (afull),
    .count     (count),
    .ovf       (ovf),
    .unf       (unf),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every rd_valid pulse must carry the oldest outstanding written word.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_spurious", 32'd1, 32'd0);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("rd_data_order", rd_data, e);
        $display("read  data=%0d", rd_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] v);
    wr_en = 1'b1; wr_data = v;
    #1;
    check("wr_wea", ram_wea, 1'b1);
    check("wr_dina", ram_dina, v);
    $display("write addr=%0d data=%0d", ram_addra, v);
    exp_q.push_back(v);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b1; wr_data = '0; rd_en = 1'b1;
    ram_doutb = '0;
    #2;
    check("rst_wea", ram_wea, 1'b0);
    check("rst_enb", ram_enb, 1'b0);
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_afull", afull, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_ovf_unf", {ovf, unf}, 2'b00);
    wr_en = 1'b0; rd_en = 1'b0;
    rst_n = 1'b1;
    tick();

    // Three writes at addresses 0..2
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = DW'(9 + i);
      #1;
      check("w3_addra", ram_addra, i);
      tick();
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(DW'(9 + i));
    wr_en = 1'b0;
    check("w3_count", count, 3);
    check("w3_empty", empty, 1'b0);

    // Three back-to-back reads with 1-cycle latency
    for (int i = 0; i < 4; i++) begin
      rd_en = (i < 3);
      #1;
      if (i < 3) begin
        check("r3_enb", ram_enb, 1'b1);
        check("r3_addrb", ram_addrb, i);
      end
      if (i == 0) check("r3_valid0", rd_valid, 1'b0);
      else begin
        check("r3_valid", rd_valid, 1'b1);
        check("r3_data", rd_data, 9 + i - 1);
      end
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    check("r3_empty", empty, 1'b1);
    check("r3_valid_end", rd_valid, 1'b0);

    // Fill to 256; write pointer starts at 3 and wraps
    for (int i = 0; i < 256; i++) begin
      if (i == 251) check("afull_251", afull, 1'b0);
      if (i == 252) begin
        check("afull_252", afull, 1'b1);
        check("count_252", count, 252);
      end
      if (i == 255) check("full_255", full, 1'b0);
      write_word(DW'(i));
    end
    check("fill_count", count, 256);
    check("fill_full", full, 1'b1);
    check("fill_afull", afull, 1'b1);
    check("fill_ovf0", ovf, 1'b0);
    wr_en = 1'b1; wr_data = 16'hDEAD;
    #1;
    check("ovf_wea", ram_wea, 1'b0);
    tick();
    wr_en = 1'b0;
    check("ovf_set", ovf, 1'b1);
    check("ovf_count", count, 256);

    // Drain to 10 entries
    rd_en = 1'b1;
    for (int i = 0; i < 246; i++) tick();
    rd_en = 1'b0;
    tick();
    check("drain_count", count, 10);
    check("drain_full", full, 1'b0);

    // Simultaneous read+write for 20 cycles; read pointer wraps past 255
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(1000 + i);
      #1;
      check("rw_addrb", ram_addrb, (249 + i) % 256);
      check("rw_addra", ram_addra, (3 + i) % 256);
      check("rw_both", {ram_wea, ram_enb}, 2'b11);
      exp_q.push_back(DW'(1000 + i));
      tick();
      check("rw_count", count, 10);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rd_en = 1'b0;
    tick();
    check("rw_empty", empty, 1'b1);
    check("rw_q_drained", exp_q.size(), 0);

    // Read while empty, then write+read together while empty
    rd_en = 1'b1;
    #1;
    check("unf_enb", ram_enb, 1'b0);
    tick();
    check("unf_valid", rd_valid, 1'b0);
    check("unf_set", unf, 1'b1);
    wr_en = 1'b1; wr_data = 16'd77;
    #1;
    check("e_rw_wea", ram_wea, 1'b1);
    check("e_rw_enb", ram_enb, 1'b0);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("e_rw_count", count, 1);
    check("ovf_sticky", ovf, 1'b1);

    // Flush: requests ignored, everything cleared
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    #1;
    check("flush_ports", {ram_wea, ram_enb}, 2'b00);
    tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check("flush_unf", unf, 1'b0);
    check("flush_ovf", ovf, 1'b0);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1'b1);
    exp_q.delete();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      #1;
      check("post_flush_addra", ram_addra, i);
      write_word(DW'(500 + i));
    end
    check("pre_rst_count", count, 5);
    rd_en = 1'b1;
    tick();
    check("pre_rst_valid", rd_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_count", count, 0);
    check("arst_valid", rd_valid, 1'b0);
    check("arst_empty", empty, 1'b1);
    check("arst_enb", ram_enb, 1'b0);
    tick();
    rd_en = 1'b0;
    rst_n = 1'b1;
    tick();
    #1;
    check("recover_addra", ram_addra, 0);
    write_word(16'd321);
    rd_en = 1'b1;
    #1;
    check("recover_addrb", ram_addrb, 0);
    tick();
    rd_en = 1'b0;
    tick();
    check("recover_q", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
